// File: rtl/puncturer_pkg.sv
// Shared puncturing definitions: rate codes, pattern periods and keep masks,
// plus the lookup helpers used by the puncturer and the transmit controller.
package puncturer_pkg;

   localparam logic [1:0] RATE_1_2 = 2'b00;
   localparam logic [1:0] RATE_2_3 = 2'b01;
   localparam logic [1:0] RATE_3_4 = 2'b10;

   // Pattern period (pairs per repetition) for each rate.
   localparam logic [1:0] PERIOD_1_2 = 2'd1;
   localparam logic [1:0] PERIOD_2_3 = 2'd2;
   localparam logic [1:0] PERIOD_3_4 = 2'd3;

   // Keep masks: phase p occupies bits [2p+1:2p]; bit 1 keeps A, bit 0 keeps B.
   localparam logic [5:0] KEEP_1_2 = 6'b11_11_11;
   localparam logic [5:0] KEEP_2_3 = 6'b00_10_11;
   localparam logic [5:0] KEEP_3_4 = 6'b01_10_11;

   // Period for a rate code; the reserved code behaves as rate 1/2.
   function automatic logic [1:0] rate_period(input logic [1:0] r);
      logic [1:0] p;
      case (r)
         RATE_2_3: p = PERIOD_2_3;
         RATE_3_4: p = PERIOD_3_4;
         default:  p = PERIOD_1_2;
      endcase
      return p;
   endfunction

   // {keep A, keep B} for a rate code and pattern phase.
   function automatic logic [1:0] keep_mask(input logic [1:0] r, input logic [1:0] ph);
      logic [5:0] m;
      case (r)
         RATE_2_3: m = KEEP_2_3;
         RATE_3_4: m = KEEP_3_4;
         default:  m = KEEP_1_2;
      endcase
      m = m >> {ph, 1'b0};
      return m[1:0];
   endfunction

endpackage

// File: rtl/puncturer.sv
// Puncturer: drops encoder bits according to the selected code rate and
// serialises the kept bits (A before B) through a two-entry holding buffer.
module puncturer
   import puncturer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] rate,
   input  logic       frame_start,
   input  logic [1:0] in_pair,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       out_bit,
   output logic       out_valid,
   input  logic       out_ready
);

   logic [1:0] rate_reg, rate_next;
   logic [1:0] phase_reg, phase_next;
   logic [1:0] count_reg, count_next;
   logic [1:0] buf_reg, buf_next;      // buf_reg[0] is the oldest entry
   logic       valid_reg, valid_next;

   logic       consume;
   logic       accept;
   logic [1:0] eff_rate;
   logic [1:0] eff_phase;
   logic [1:0] keep;
   logic [1:0] period;

   assign consume   = valid_reg & out_ready;
   assign in_ready  = (count_reg == 2'd0) || ((count_reg == 2'd1) && consume);
   assign accept    = in_valid & in_ready;
   assign out_valid = valid_reg;
   assign out_bit   = buf_reg[0];

   // Next-state: frame_start takes effect for a pair accepted in the same cycle.
   always_comb begin
      eff_rate   = frame_start ? rate : rate_reg;
      eff_phase  = frame_start ? 2'd0 : phase_reg;
      keep       = keep_mask(eff_rate, eff_phase);
      period     = rate_period(eff_rate);
      rate_next  = eff_rate;
      phase_next = eff_phase;
      buf_next   = buf_reg;
      count_next = count_reg;

      if (consume) begin
         buf_next   = {1'b0, buf_reg[1]};
         count_next = count_reg - 2'd1;
      end

      // A pair is only accepted when the buffer is empty after the shift,
      // so the kept bits always land at the head of the buffer.
      if (accept) begin
         phase_next = (eff_phase == (period - 2'd1)) ? 2'd0 : eff_phase + 2'd1;
         case (keep)
            2'b11: begin
               buf_next   = {in_pair[0], in_pair[1]};
               count_next = 2'd2;
            end
            2'b10: begin
               buf_next   = {1'b0, in_pair[1]};
               count_next = 2'd1;
            end
            2'b01: begin
               buf_next   = {1'b0, in_pair[0]};
               count_next = 2'd1;
            end
            default: begin
               buf_next   = 2'b00;
               count_next = 2'd0;
            end
         endcase
      end

      valid_next = (count_next != 2'd0);
   end

   // State registers; reset discards held bits and restarts the pattern at rate 1/2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rate_reg  <= RATE_1_2;
         phase_reg <= 2'd0;
         count_reg <= 2'd0;
         buf_reg   <= 2'b00;
         valid_reg <= 1'b0;
      end else begin
         rate_reg  <= rate_next;
         phase_reg <= phase_next;
         count_reg <= count_next;
         buf_reg   <= buf_next;
         valid_reg <= valid_next;
      end
   end

endmodule

// File: doc/puncturer.md
PUNCTURER -- requirements
Module: puncturer

Interface
REQ-001 Parameters: none; all behaviour is fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low.
REQ-004 rate  input  2  code-rate select: 00=1/2, 01=2/3, 10=3/4, 11=reserved (treated as 1/2).
REQ-005 frame_start  input  1  one-cycle pulse; latches rate and zeroes pattern phase.
REQ-006 in_pair  input  2  encoded pair from convolutional encoder; bit1=A (first-transmitted), bit0=B.
REQ-007 in_valid  input  1  in_pair valid.
REQ-008 in_ready  output  1  puncturer can accept in_pair this cycle.
REQ-009 out_bit  output  1  serial punctured bit.
REQ-010 out_valid  output  1  out_bit valid.
REQ-011 out_ready  input  1  downstream accepts out_bit this cycle.

Function
REQ-012 A pair is accepted on a cycle with in_valid=1 and in_ready=1; an output bit is consumed on a cycle with out_valid=1 and out_ready=1.
REQ-013 Pattern phase counter advances by one per accepted pair and wraps at the period: 1 for 1/2, 2 for 2/3, 3 for 3/4.
REQ-014 Rate 1/2: every phase keeps A then B.
REQ-015 Rate 2/3: phase 0 keeps A,B; phase 1 keeps A only (B dropped).
REQ-016 Rate 3/4: phase 0 keeps A,B; phase 1 keeps A only; phase 2 keeps B only.
REQ-017 Kept bits are emitted in order A before B, pair order preserved, no bit lost or duplicated.
REQ-018 Internal holding buffer has 2 bit entries plus a 2-bit occupancy count (0..2); out_bit is the oldest entry.
REQ-019 in_ready = (count==0) or (count==1 and an output is consumed this cycle); combinational from count, out_valid, out_ready only (no path from in_valid).
REQ-020 out_valid = (count!=0); out_valid and out_bit come from registers.
REQ-021 Latency: a bit kept from a pair accepted at edge N is presented at out_bit after edge N when it is oldest; minimum 1 cycle.
REQ-022 Simultaneous accept and consume in one cycle: count_next = count - 1 + kept_bits; buffer shifts before append.
REQ-023 Throughput with out_ready held 1: at most one bit per cycle on out_bit; no bubbles while input is continuously valid.
REQ-024 With out_ready held 0, out_bit and out_valid hold stable; count never exceeds 2.
REQ-025 frame_start: the effective rate register loads rate and the phase counter loads 0 on that edge; a pair accepted in the same cycle uses the new rate and phase 0.
REQ-026 frame_start does not flush the buffer; bits already held drain unchanged.
REQ-027 rate changes without frame_start have no effect.

Reset
REQ-028 On rst=0: count=0, buffer=0, phase=0, effective rate=00, out_valid=0, out_bit=0, in_ready=1 on the next cycle with rst=1.
REQ-029 Reset asserted mid-frame discards all held bits immediately; no partial pattern survives.

Structure
REQ-030 Shared package holds rate-code constants (RATE_1_2, RATE_2_3, RATE_3_4) and per-rate period/keep-mask constants used by this block and the transmit controller.
REQ-031 Single module; the keep-mask lookup (rate, phase -> keep A, keep B) is a function, not a sub-module.

Verification
REQ-032 Rate 1/2, out_ready=1, pairs 10,01,11 back-to-back -> out_bit stream 1,0,0,1,1,1; in_ready deasserts on alternate cycles.
REQ-033 Rate 2/3 after frame_start, pairs 11,10,01,11 -> stream 1,1,1,0,1,1 (4 pairs -> 6 bits).
REQ-034 Rate 3/4 after frame_start, pairs 10,11,01 -> stream 1,0,1,1 (A2 and B1 dropped).
REQ-035 out_ready=0 for 5 cycles with count=2 -> out_bit/out_valid stable, in_ready=0, no input accepted; release -> held bits drain in order.
REQ-036 Rate 3/4, frame_start pulsed at phase 2 with a concurrent pair 01 -> pair treated as phase 0, stream 0,1.
REQ-037 rst asserted with count=2 mid-frame -> out_valid=0 immediately; after release, first pair uses phase 0 and rate 1/2.
